// File: rtl/uart_dut_sequencer_pkg.sv
// Shared definitions for the UART-to-DUT command sequencer: command codes,
// status byte layout and FSM state encoding.
package sequencer_pkg;

   localparam logic [3:0] CMD_ECHO      = 4'h0;
   localparam logic [3:0] CMD_EXEC      = 4'h1;
   localparam logic [3:0] CMD_READ_LAST = 4'h2;

   localparam int ST_ANY_ERR = 7;
   localparam int ST_TIMEOUT = 6;
   localparam int ST_BADCMD  = 5;
   localparam int ST_DUTERR  = 4;

   typedef enum logic [2:0] {
      IDLE     = 3'd0,
      DECODE   = 3'd1,
      WAIT_DUT = 3'd2,
      SEND     = 3'd3,
      WAIT_TX  = 3'd4,
      CLEAR    = 3'd5
   } state_e;

   function automatic logic [7:0] make_status(input logic       timeout,
                                              input logic       badcmd,
                                              input logic       duterr,
                                              input logic [3:0] seq);
      logic [7:0] s;
      s             = '0;
      s[3:0]        = seq;
      s[ST_DUTERR]  = duterr;
      s[ST_BADCMD]  = badcmd;
      s[ST_TIMEOUT] = timeout;
      s[ST_ANY_ERR] = timeout | badcmd | duterr;
      return s;
   endfunction

endpackage

// File: rtl/uart_dut_sequencer_timeout.sv
// Watchdog for the DUT handshake: counts enabled cycles from a clear and flags
// the cycle in which the count sits at TIMEOUT_CYCLES-1.
module seq_timeout_counter #(
   parameter int TIMEOUT_CYCLES = 1000000,
   parameter int TIMEOUT_BITS   = $clog2(TIMEOUT_CYCLES + 1)
) (
   input  logic clk_i,
   input  logic rst_i,
   input  logic clr_i,
   input  logic en_i,
   output logic expired_o
);

   localparam logic [TIMEOUT_BITS-1:0] LAST = TIMEOUT_BITS'(TIMEOUT_CYCLES - 1);

   logic [TIMEOUT_BITS-1:0] count_q, count_d;

   always_comb begin
      count_d = count_q;
      if (clr_i) begin
         count_d = '0;
      end else if (en_i && (count_q != LAST)) begin
         count_d = count_q + TIMEOUT_BITS'(1);
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         count_q <= '0;
      end else begin
         count_q <= count_d;
      end
   end

   assign expired_o = en_i && (count_q == LAST);

endmodule

// File: rtl/uart_dut_sequencer.sv
// Sequencer between the wide UART I/O block and a DUT: decodes each host packet,
// runs the DUT start/done handshake under a watchdog and returns a status+data response.
module uart_dut_sequencer
   import sequencer_pkg::*;
#(
   parameter int WIDTH          = 4,
   parameter int TIMEOUT_CYCLES = 1000000,
   parameter int TIMEOUT_BITS   = $clog2(TIMEOUT_CYCLES + 1)
) (
   input  logic               masterClock,
   input  logic               reset,
   input  logic [7:0]         linkControl,
   input  logic [WIDTH*8-1:0] linkInputData,
   input  logic               linkDataReceived,
   input  logic               linkTransmitting,
   output logic               linkClearDR,
   output logic               linkTransmit,
   output logic [7:0]         linkStatus,
   output logic [WIDTH*8-1:0] linkOutputData,
   output logic [3:0]         dutOpcode,
   output logic [WIDTH*8-1:0] dutOperand,
   output logic               dutStart,
   input  logic               dutDone,
   input  logic [WIDTH*8-1:0] dutResult,
   input  logic               dutError,
   output logic               busy
);

   localparam int DW = WIDTH * 8;

   state_e          state_q, state_d;
   logic [7:0]      ctrl_q, ctrl_d;
   logic [DW-1:0]   data_q, data_d;
   logic [3:0]      seq_q, seq_d;
   logic [DW-1:0]   last_q, last_d;
   logic            clear_dr_q, clear_dr_d;
   logic            transmit_q, transmit_d;
   logic [7:0]      status_q, status_d;
   logic [DW-1:0]   out_q, out_d;
   logic [3:0]      opcode_q, opcode_d;
   logic [DW-1:0]   operand_q, operand_d;
   logic            start_q, start_d;
   logic            busy_q, busy_d;
   logic [3:0]      seq_inc;
   logic            expired;

   seq_timeout_counter #(
      .TIMEOUT_CYCLES (TIMEOUT_CYCLES),
      .TIMEOUT_BITS   (TIMEOUT_BITS)
   ) u_timeout (
      .clk_i     (masterClock),
      .rst_i     (reset),
      .clr_i     (state_q == DECODE),
      .en_i      (state_q == WAIT_DUT),
      .expired_o (expired)
   );

   // Every response carries the post-increment sequence number.
   assign seq_inc = seq_q + 4'd1;

   always_comb begin
      state_d    = state_q;
      ctrl_d     = ctrl_q;
      data_d     = data_q;
      seq_d      = seq_q;
      last_d     = last_q;
      clear_dr_d = clear_dr_q;
      transmit_d = transmit_q;
      status_d   = status_q;
      out_d      = out_q;
      opcode_d   = opcode_q;
      operand_d  = operand_q;
      start_d    = 1'b0;

      unique case (state_q)
         IDLE: begin
            if (linkDataReceived) begin
               ctrl_d  = linkControl;
               data_d  = linkInputData;
               state_d = DECODE;
            end
         end
         DECODE: begin
            if (ctrl_q[7:4] == CMD_EXEC) begin
               opcode_d  = ctrl_q[3:0];
               operand_d = data_q;
               start_d   = 1'b1;
               state_d   = WAIT_DUT;
            end else begin
               seq_d      = seq_inc;
               transmit_d = 1'b1;
               state_d    = SEND;
               if (ctrl_q[7:4] == CMD_ECHO) begin
                  status_d = make_status(1'b0, 1'b0, 1'b0, seq_inc);
                  out_d    = data_q;
               end else if (ctrl_q[7:4] == CMD_READ_LAST) begin
                  status_d = make_status(1'b0, 1'b0, 1'b0, seq_inc);
                  out_d    = last_q;
               end else begin
                  status_d = make_status(1'b0, 1'b1, 1'b0, seq_inc);
                  out_d    = '0;
               end
            end
         end
         WAIT_DUT: begin
            // A result arriving in the expiry cycle still counts as a result.
            if (dutDone) begin
               out_d      = dutResult;
               last_d     = dutResult;
               status_d   = make_status(1'b0, 1'b0, dutError, seq_inc);
               seq_d      = seq_inc;
               transmit_d = 1'b1;
               state_d    = SEND;
            end else if (expired) begin
               out_d      = '0;
               status_d   = make_status(1'b1, 1'b0, 1'b0, seq_inc);
               seq_d      = seq_inc;
               transmit_d = 1'b1;
               state_d    = SEND;
            end
         end
         SEND: begin
            if (linkTransmitting) begin
               transmit_d = 1'b0;
               state_d    = WAIT_TX;
            end
         end
         WAIT_TX: begin
            if (!linkTransmitting) begin
               clear_dr_d = 1'b1;
               state_d    = CLEAR;
            end
         end
         CLEAR: begin
            if (!linkDataReceived) begin
               clear_dr_d = 1'b0;
               state_d    = IDLE;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase

      busy_d = (state_d != IDLE);
   end

   always_ff @(posedge masterClock) begin
      if (reset) begin
         state_q    <= IDLE;
         ctrl_q     <= '0;
         data_q     <= '0;
         seq_q      <= '0;
         last_q     <= '0;
         clear_dr_q <= 1'b0;
         transmit_q <= 1'b0;
         status_q   <= '0;
         out_q      <= '0;
         opcode_q   <= '0;
         operand_q  <= '0;
         start_q    <= 1'b0;
         busy_q     <= 1'b0;
      end else begin
         state_q    <= state_d;
         ctrl_q     <= ctrl_d;
         data_q     <= data_d;
         seq_q      <= seq_d;
         last_q     <= last_d;
         clear_dr_q <= clear_dr_d;
         transmit_q <= transmit_d;
         status_q   <= status_d;
         out_q      <= out_d;
         opcode_q   <= opcode_d;
         operand_q  <= operand_d;
         start_q    <= start_d;
         busy_q     <= busy_d;
      end
   end

   assign linkClearDR    = clear_dr_q;
   assign linkTransmit   = transmit_q;
   assign linkStatus     = status_q;
   assign linkOutputData = out_q;
   assign dutOpcode      = opcode_q;
   assign dutOperand     = operand_q;
   assign dutStart       = start_q;
   assign busy           = busy_q;

endmodule
